// File: rtl/gray_pkg.sv
// Shared constants, action encoding and Gray-code helpers for the Gray counter.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  // Per-edge action selected by the control inputs (reset handled separately).
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_UP,
    ACT_DOWN,
    ACT_LOAD
  } cnt_act_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray_f(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin_f(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int unsigned i = GRAY_MAX_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter, N bits wide.
module bin2gray #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] i_bin,
  output logic [N-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with registered Gray and binary outputs, a
// combinational next-Gray lookahead and a registered terminal-count pulse.
// Optional synchronous load (LD/LDV) is compiled in with GRAY_CNT_LOAD_EN.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned    N       = 8,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         UP,
`ifdef GRAY_CNT_LOAD_EN
  input  logic         LD,
  input  logic [N-1:0] LDV,
`endif
  output logic [N-1:0] GO,
  output logic [N-1:0] BO,
  output logic [N-1:0] GNX,
  output logic         TC
);

  localparam logic [GRAY_MAX_W-1:0] RST_G32  = bin2gray_f(GRAY_MAX_W'(RST_VAL));
  localparam logic [N-1:0]          RST_GRAY = RST_G32[N-1:0];

  logic [N-1:0] r_bo;
  logic [N-1:0] r_go;
  logic         r_tc;

  cnt_act_e     w_act;
  logic [N-1:0] w_bin_nx;
  logic [N-1:0] w_gnx;
  logic         w_wrap;

  // Decode the control inputs into one action; load outranks counting.
  always_comb begin
    w_act = ACT_HOLD;
    if (EN) begin
      w_act = UP ? ACT_UP : ACT_DOWN;
    end
`ifdef GRAY_CNT_LOAD_EN
    if (LD) begin
      w_act = ACT_LOAD;
    end
`endif
  end

  // Next binary value and wrap detection for the selected action.
  always_comb begin
    w_bin_nx = r_bo;
    w_wrap   = 1'b0;
    unique case (w_act)
      ACT_UP: begin
        w_bin_nx = r_bo + 1'b1;
        w_wrap   = &r_bo;
      end
      ACT_DOWN: begin
        w_bin_nx = r_bo - 1'b1;
        w_wrap   = ~|r_bo;
      end
`ifdef GRAY_CNT_LOAD_EN
      ACT_LOAD: begin
        w_bin_nx = LDV;
      end
`endif
      default: begin
      end
    endcase
  end

  bin2gray #(
    .N(N)
  ) u_bin2gray (
    .i_bin  (w_bin_nx),
    .o_gray (w_gnx)
  );

  // State registers; GO comes straight from a flop so it is glitch-free.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bo <= RST_VAL;
      r_go <= RST_GRAY;
      r_tc <= 1'b0;
    end else begin
      r_bo <= w_bin_nx;
      r_go <= w_gnx;
      r_tc <= w_wrap;
    end
  end

  assign GO  = r_go;
  assign BO  = r_bo;
  assign GNX = w_gnx;
  assign TC  = r_tc;

endmodule
